decoder8_sequencer: RTL and testbench

DECODER8_SEQUENCER -- requirements
Module: decoder8_sequencer

---
 rtl/alu4_pkg.sv | 18 +
 rtl/sync_fifo.sv | 68 ++++++
 rtl/decoder8_sequencer.sv | 115 +++++++++++
 tb/tb_decoder8_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu4_pkg.sv
// Shared types for the decoder8 command sequencer: command word and FSM states.
package alu4_pkg;

    localparam int SEL_W  = 3;
    localparam int HOLD_W = 4;

    // One queued command: which decoder line to drive and for how long (minus one).
    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [HOLD_W-1:0] hold;
    } cmd_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count; pointers wrap naturally since DEPTH is a power of two.
module sync_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  T                       wdata,
    input  logic                   pop,
    output T                       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    T              mem_q [DEPTH];

    logic doPush;
    logic doPop;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign rdata  = mem_q[rptr_q];
    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    // Pointer and occupancy bookkeeping; flush empties the queue and wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (doPop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (doPush && !doPop) begin
                count_q <= count_q + CW'(1);
            end else if (doPop && !doPush) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Storage array; contents need no reset because empty/count gate every read.
    always_ff @(posedge clk) begin
        if (doPush && !flush) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/decoder8_sequencer.sv
// Queues {sel, hold} commands and plays them out as back-to-back enable windows for a decoder8.
module decoder8_sequencer
    import alu4_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic [HOLD_W-1:0]      in_hold,
    output logic                   enable,
    output logic [SEL_W-1:0]       select,
    output logic                   done,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
);

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] remain_q, remain_d;
    logic              enable_q, enable_d;
    logic [SEL_W-1:0]  select_q, select_d;

    cmd_t inCmd;
    cmd_t headCmd;
    logic fifoPush;
    logic fifoPop;
    logic fifoFull;
    logic fifoEmpty;

    assign inCmd    = '{sel: in_sel, hold: in_hold};
    assign in_ready = rst_n && !fifoFull && !flush;
    assign fifoPush = in_valid && in_ready;

    sync_fifo #(
        .DEPTH (DEPTH),
        .T     (cmd_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (fifoPush),
        .wdata (inCmd),
        .pop   (fifoPop),
        .rdata (headCmd),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (count)
    );

    assign enable = enable_q;
    assign select = select_q;
    assign done   = (state_q == ISSUE) && (remain_q == '0);
    assign busy   = (state_q == ISSUE) || !fifoEmpty;

    // FSM and output registers; reset clears everything including the last select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            remain_q <= '0;
            enable_q <= 1'b0;
            select_q <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            enable_q <= enable_d;
            select_q <= select_d;
        end
    end

    // Next state: load from the FIFO head in IDLE or at the end of a window so enable never gaps.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        enable_d = enable_q;
        select_d = select_q;
        fifoPop  = 1'b0;
        if (flush) begin
            state_d  = IDLE;
            remain_d = '0;
            enable_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifoEmpty) begin
                        fifoPop  = 1'b1;
                        select_d = headCmd.sel;
                        remain_d = headCmd.hold;
                        enable_d = 1'b1;
                        state_d  = ISSUE;
                    end
                end
                ISSUE: begin
                    if (remain_q != '0) begin
                        remain_d = remain_q - HOLD_W'(1);
                    end else if (!fifoEmpty) begin
                        fifoPop  = 1'b1;
                        select_d = headCmd.sel;
                        remain_d = headCmd.hold;
                    end else begin
                        enable_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    enable_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder8_sequencer.sv
// Directed self-checking bench for decoder8_sequencer with a decoder8 reference on its outputs.
module tb_decoder8_sequencer;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_sel;
    logic [3:0] in_hold;
    logic       enable;
    logic [2:0] select;
    logic       done;
    logic       busy;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;
    int enCount = 0;
    logic [2:0] doneLog[$];

    decoder8_sequencer #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_hold  (in_hold),
        .enable   (enable),
        .select   (select),
        .done     (done),
        .busy     (busy),
        .count    (count)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decoder8 fed by the sequencer outputs.
    function automatic logic [7:0] decode8(input logic en, input logic [2:0] s);
        logic [7:0] one;
        one = 8'b0000_0001;
        decode8 = en ? (one << s) : 8'b0;
    endfunction

    // Log the selected line of every finished command and count enable cycles, mid-cycle.
    always @(negedge clk) begin
        if (done) doneLog.push_back(select);
        if (enable) enCount = enCount + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) tick;
        checks++; if (enable !== 1'b0) begin errors++; $display("[TB] FAIL rst_enable: got %b want 0", enable); end
        checks++; if (select !== 3'd0) begin errors++; $display("[TB] FAIL rst_select: got %0d want 0", select); end
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL rst_count: got %0d want 0", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_ready: got %b want 0", in_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rst_done: got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single;
        in_sel = 3'd5; in_hold = 4'd0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        checks++; if (count !== 3'd1) begin errors++; $display("[TB] FAIL single_count_acc: got %0d want 1", count); end
        checks++; if (enable !== 1'b0) begin errors++; $display("[TB] FAIL single_en_acc: got %b want 0", enable); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_acc: got %b want 1", busy); end
        tick;
        checks++; if (enable !== 1'b1) begin errors++; $display("[TB] FAIL single_en: got %b want 1", enable); end
        checks++; if (select !== 3'd5) begin errors++; $display("[TB] FAIL single_sel: got %0d want 5", select); end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL single_done: got %b want 1", done); end
        checks++; if (decode8(enable, select) !== 8'h20) begin errors++; $display("[TB] FAIL single_dec: got %h want 20", decode8(enable, select)); end
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL single_count_pop: got %0d want 0", count); end
        tick;
        checks++; if (enable !== 1'b0) begin errors++; $display("[TB] FAIL single_en_end: got %b want 0", enable); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL single_done_end: got %b want 0", done); end
        checks++; if (select !== 3'd5) begin errors++; $display("[TB] FAIL single_sel_hold: got %0d want 5", select); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_end: got %b want 0", busy); end
        checks++; if (decode8(enable, select) !== 8'h00) begin errors++; $display("[TB] FAIL single_dec_end: got %h want 00", decode8(enable, select)); end
    endtask

    task automatic test_back_to_back;
        logic [2:0] expSel[6]  = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd7, 3'd7};
        logic       expDone[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] expDec[6]  = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h80, 8'h80};
        in_sel = 3'd2; in_hold = 4'd3; in_valid = 1'b1;
        tick;
        in_sel = 3'd7; in_hold = 4'd1;
        tick;
        in_valid = 1'b0;
        checks++; if (count !== 3'd1) begin errors++; $display("[TB] FAIL b2b_count_pushpop: got %0d want 1", count); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (enable !== 1'b1) begin errors++; $display("[TB] FAIL b2b_en[%0d]: got %b want 1", i, enable); end
            checks++; if (select !== expSel[i]) begin errors++; $display("[TB] FAIL b2b_sel[%0d]: got %0d want %0d", i, select, expSel[i]); end
            checks++; if (done !== expDone[i]) begin errors++; $display("[TB] FAIL b2b_done[%0d]: got %b want %b", i, done, expDone[i]); end
            checks++; if (decode8(enable, select) !== expDec[i]) begin errors++; $display("[TB] FAIL b2b_dec[%0d]: got %h want %h", i, decode8(enable, select), expDec[i]); end
            tick;
        end
        checks++; if (enable !== 1'b0) begin errors++; $display("[TB] FAIL b2b_en_end: got %b want 0", enable); end
        checks++; if (select !== 3'd7) begin errors++; $display("[TB] FAIL b2b_sel_hold: got %0d want 7", select); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_end: got %b want 0", done); end
    endtask

    task automatic test_full_wrap;
        logic [2:0] cmdSel[6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5};
        int waited;
        doneLog.delete();
        enCount = 0;
        for (int k = 0; k < 6; k++) begin
            in_sel = cmdSel[k]; in_hold = 4'd15; in_valid = 1'b1;
            waited = 0;
            while (!in_ready && waited < 100) begin
                tick;
                waited++;
            end
            if (k == 5) begin
                checks++; if (waited !== 13) begin errors++; $display("[TB] FAIL full_wait_cycles: got %0d want 13", waited); end
            end
            tick;
            if (k == 4) begin
                checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL full_count: got %0d want 4", count); end
                checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready: got %b want 0", in_ready); end
            end
        end
        in_valid = 1'b0;
        checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL full_count_refill: got %0d want 4", count); end
        waited = 0;
        while (busy && waited < 300) begin
            tick;
            waited++;
        end
        checks++; if (waited >= 300) begin errors++; $display("[TB] FAIL full_drain_timeout: got %0d cycles want <300", waited); end
        checks++; if (doneLog.size() !== 6) begin errors++; $display("[TB] FAIL full_done_count: got %0d want 6", doneLog.size()); end
        for (int i = 0; i < 6; i++) begin
            if (i < doneLog.size()) begin
                checks++; if (doneLog[i] !== cmdSel[i]) begin errors++; $display("[TB] FAIL full_order[%0d]: got %0d want %0d", i, doneLog[i], cmdSel[i]); end
            end
        end
        checks++; if (enCount !== 96) begin errors++; $display("[TB] FAIL full_en_cycles: got %0d want 96", enCount); end
    endtask

    task automatic test_flush;
        logic [2:0] cmdSel[4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        doneLog.delete();
        for (int k = 0; k < 4; k++) begin
            in_sel = cmdSel[k]; in_hold = 4'd15; in_valid = 1'b1;
            tick;
        end
        checks++; if (count !== 3'd3) begin errors++; $display("[TB] FAIL flush_pre_count: got %0d want 3", count); end
        checks++; if (enable !== 1'b1) begin errors++; $display("[TB] FAIL flush_pre_en: got %b want 1", enable); end
        checks++; if (select !== 3'd1) begin errors++; $display("[TB] FAIL flush_pre_sel: got %0d want 1", select); end
        in_sel = 3'd7; in_hold = 4'd0; in_valid = 1'b1; flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_ready: got %b want 0", in_ready); end
        tick;
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (enable !== 1'b0) begin errors++; $display("[TB] FAIL flush_en: got %b want 0", enable); end
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL flush_count: got %0d want 0", count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL flush_done: got %b want 0", done); end
        enCount = 0;
        repeat (20) tick;
        checks++; if (enCount !== 0) begin errors++; $display("[TB] FAIL flush_no_issue: got %0d enable cycles want 0", enCount); end
        checks++; if (doneLog.size() !== 0) begin errors++; $display("[TB] FAIL flush_no_done: got %0d want 0", doneLog.size()); end
    endtask

    task automatic test_reset_mid;
        doneLog.delete();
        in_sel = 3'd4; in_hold = 4'd10; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        checks++; if (enable !== 1'b1) begin errors++; $display("[TB] FAIL mid_en: got %b want 1", enable); end
        checks++; if (select !== 3'd4) begin errors++; $display("[TB] FAIL mid_sel: got %0d want 4", select); end
        repeat (3) tick;
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (enable !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_en: got %b want 0", enable); end
        checks++; if (select !== 3'd0) begin errors++; $display("[TB] FAIL mid_rst_sel: got %0d want 0", select); end
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL mid_rst_count: got %0d want 0", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_ready: got %b want 0", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_done: got %b want 0", done); end
        #4;
        rst_n = 1'b1;
        enCount = 0;
        repeat (20) tick;
        checks++; if (enCount !== 0) begin errors++; $display("[TB] FAIL mid_no_issue: got %0d enable cycles want 0", enCount); end
        checks++; if (doneLog.size() !== 0) begin errors++; $display("[TB] FAIL mid_no_done: got %0d want 0", doneLog.size()); end
        in_sel = 3'd3; in_hold = 4'd0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        checks++; if (enable !== 1'b0) begin errors++; $display("[TB] FAIL mid_new_acc: got %b want 0", enable); end
        tick;
        checks++; if (enable !== 1'b1) begin errors++; $display("[TB] FAIL mid_new_en: got %b want 1", enable); end
        checks++; if (select !== 3'd3) begin errors++; $display("[TB] FAIL mid_new_sel: got %0d want 3", select); end
        checks++; if (decode8(enable, select) !== 8'h08) begin errors++; $display("[TB] FAIL mid_new_dec: got %h want 08", decode8(enable, select)); end
        tick;
        checks++; if (enable !== 1'b0) begin errors++; $display("[TB] FAIL mid_new_end: got %b want 0", enable); end
    endtask

    // Guard against a stuck design so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence.
    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_sel = 3'd0;
        in_hold = 4'd0;
        test_reset;
        test_single;
        test_back_to_back;
        test_full_wrap;
        test_flush;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
